// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/bubble controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         DEF_MD_LATENCY  = 8;
  localparam int         DEF_MEM_TIMEOUT = 64;
  localparam int         MD_CNT_W        = 5;
  localparam int         WAIT_CNT_W      = 8;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_bubble;
    logic idex_stall;
    logic idex_bubble;
    logic exmem_stall;
    logic exmem_bubble;
    logic memwb_stall;
    logic memwb_bubble;
  } stage_ctrl_t;

  // A source register only creates a dependency when the instruction actually reads it.
  function automatic logic reg_hit(input logic uses, input logic [4:0] src, input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Busy-window counter for a multi-cycle arithmetic unit: loads on an accepted start,
// then counts down to zero; busy while nonzero.
module md_busy_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int LATENCY = DEF_MD_LATENCY
) (
  input  logic clk,
  input  logic nrst,
  input  logic start,
  output logic busy
);

  localparam logic [MD_CNT_W-1:0] LOAD_VAL = MD_CNT_W'(LATENCY);
  localparam logic [MD_CNT_W-1:0] CNT_ONE  = MD_CNT_W'(1);

  logic [MD_CNT_W-1:0] count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else if (start) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - CNT_ONE;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/bubble controller for the 5-stage pipeline.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY  = DEF_MD_LATENCY,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [4:0]  i_id_rs,
  input  logic [4:0]  i_id_rt,
  input  logic        i_id_uses_rs,
  input  logic        i_id_uses_rt,
  input  logic        i_id_md_start,
  input  logic        i_id_md_read,
  input  logic        i_ex_memread,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_branch_taken,
  input  logic        i_mem_req,
  input  logic        i_mem_ready,
  output logic        o_pc_stall,
  output logic        o_ifid_stall,
  output logic        o_ifid_bubble,
  output logic        o_idex_stall,
  output logic        o_idex_bubble,
  output logic        o_exmem_stall,
  output logic        o_exmem_bubble,
  output logic        o_memwb_stall,
  output logic        o_memwb_bubble,
  output logic        o_md_busy,
  output logic        o_mem_timeout,
  output logic [1:0]  o_state,
  output logic [31:0] o_perf_stall_cycles,
  output logic [31:0] o_perf_flushes
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_CNT_W-1:0] WAIT_ONE    = WAIT_CNT_W'(1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX    = '1;

  ctrl_state_t           state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [WAIT_CNT_W-1:0] wait_inc;
  logic                  timeout;
  logic                  md_busy;
  logic                  md_accept;
  logic                  load_use;
  logic                  md_hold;
  logic                  mem_hold;
  logic                  mem_stall;
  stage_ctrl_t           ctrl;

  assign load_use = i_ex_memread && (i_ex_rd != REG_ZERO) &&
                    (reg_hit(i_id_uses_rs, i_id_rs, i_ex_rd) ||
                     reg_hit(i_id_uses_rt, i_id_rt, i_ex_rd));
  assign md_hold   = md_busy && (i_id_md_read || i_id_md_start);
  assign mem_hold  = i_mem_req && !i_mem_ready;
  assign mem_stall = mem_hold || ((state == ST_MEM_WAIT) && !i_mem_ready);

  // A memory wait freezes every stage, so a pending branch flush waits for ready.
  always_comb begin
    ctrl = '0;
    if (nrst) begin
      if (mem_stall) begin
        ctrl.pc_stall    = 1'b1;
        ctrl.ifid_stall  = 1'b1;
        ctrl.idex_stall  = 1'b1;
        ctrl.exmem_stall = 1'b1;
        ctrl.memwb_stall = 1'b1;
      end else if (i_ex_branch_taken) begin
        ctrl.ifid_bubble = 1'b1;
        ctrl.idex_bubble = 1'b1;
      end else if (load_use || md_hold) begin
        ctrl.pc_stall    = 1'b1;
        ctrl.ifid_stall  = 1'b1;
        ctrl.idex_bubble = 1'b1;
      end
    end
  end

  assign o_pc_stall     = ctrl.pc_stall;
  assign o_ifid_stall   = ctrl.ifid_stall;
  assign o_ifid_bubble  = ctrl.ifid_bubble;
  assign o_idex_stall   = ctrl.idex_stall;
  assign o_idex_bubble  = ctrl.idex_bubble;
  assign o_exmem_stall  = ctrl.exmem_stall;
  assign o_exmem_bubble = ctrl.exmem_bubble;
  assign o_memwb_stall  = ctrl.memwb_stall;
  assign o_memwb_bubble = ctrl.memwb_bubble;

  assign md_accept = i_id_md_start && !ctrl.pc_stall && !ctrl.idex_bubble;

  md_busy_counter #(
    .LATENCY(MD_LATENCY)
  ) u_md_busy (
    .clk  (clk),
    .nrst (nrst),
    .start(md_accept),
    .busy (md_busy)
  );

  assign o_md_busy = md_busy;
  assign wait_inc  = wait_cnt + WAIT_ONE;

  // Timeout is flagged on the edge that makes wait_cnt reach the limit, so it is
  // visible during the MEM_TIMEOUT-th wait cycle itself.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_hold) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= WAIT_ONE;
            if (WAIT_ONE == TIMEOUT_VAL) timeout <= 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (i_mem_ready) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_inc;
            if (wait_inc == TIMEOUT_VAL) timeout <= 1'b1;
          end
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign o_state       = state;
  assign o_mem_timeout = timeout;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flushes;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_cycles <= '0;
      flushes      <= '0;
    end else begin
      if (ctrl.pc_stall) stall_cycles <= stall_cycles + 32'd1;
      if (i_ex_branch_taken && !mem_stall) flushes <= flushes + 32'd1;
    end
  end

  assign o_perf_stall_cycles = stall_cycles;
  assign o_perf_flushes      = flushes;
`else
  assign o_perf_stall_cycles = '0;
  assign o_perf_flushes      = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int MD_LAT = 8;
  localparam int MEM_TO = 4;

  localparam logic [8:0] V_NONE   = 9'b000000000;
  localparam logic [8:0] V_MEM    = 9'b110101010;
  localparam logic [8:0] V_BRANCH = 9'b001010000;
  localparam logic [8:0] V_INTLK  = 9'b110010000;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       md_start;
    logic       md_read;
    logic       ex_memread;
    logic [4:0] ex_rd;
    logic       branch;
    logic       mem_req;
    logic       mem_ready;
  } stim_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic        id_uses_rs = 1'b0;
  logic        id_uses_rt = 1'b0;
  logic        id_md_start = 1'b0;
  logic        id_md_read = 1'b0;
  logic        ex_memread = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        ex_branch_taken = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_stall, ifid_stall, ifid_bubble, idex_stall, idex_bubble;
  logic        exmem_stall, exmem_bubble, memwb_stall, memwb_bubble;
  logic        md_busy, mem_timeout;
  logic [1:0]  state;
  logic [31:0] perf_stall_cycles, perf_flushes;
  logic [8:0]  dut_vec;

  int errors = 0;
  int checks = 0;

  int          md_rem = 0;
  bit          in_wait = 1'b0;
  int          wait_cycles = 0;
  bit          tmo = 1'b0;
  logic [31:0] exp_stall_cnt = '0;
  logic [31:0] exp_flush_cnt = '0;
  logic [8:0]  model_vec;
  bit          model_mstall;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MD_LATENCY (MD_LAT),
    .MEM_TIMEOUT(MEM_TO)
  ) dut (
    .clk                (clk),
    .nrst               (nrst),
    .i_id_rs            (id_rs),
    .i_id_rt            (id_rt),
    .i_id_uses_rs       (id_uses_rs),
    .i_id_uses_rt       (id_uses_rt),
    .i_id_md_start      (id_md_start),
    .i_id_md_read       (id_md_read),
    .i_ex_memread       (ex_memread),
    .i_ex_rd            (ex_rd),
    .i_ex_branch_taken  (ex_branch_taken),
    .i_mem_req          (mem_req),
    .i_mem_ready        (mem_ready),
    .o_pc_stall         (pc_stall),
    .o_ifid_stall       (ifid_stall),
    .o_ifid_bubble      (ifid_bubble),
    .o_idex_stall       (idex_stall),
    .o_idex_bubble      (idex_bubble),
    .o_exmem_stall      (exmem_stall),
    .o_exmem_bubble     (exmem_bubble),
    .o_memwb_stall      (memwb_stall),
    .o_memwb_bubble     (memwb_bubble),
    .o_md_busy          (md_busy),
    .o_mem_timeout      (mem_timeout),
    .o_state            (state),
    .o_perf_stall_cycles(perf_stall_cycles),
    .o_perf_flushes     (perf_flushes)
  );

  assign dut_vec = {pc_stall, ifid_stall, ifid_bubble, idex_stall, idex_bubble,
                    exmem_stall, exmem_bubble, memwb_stall, memwb_bubble};

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stage controls derived directly from the priority rules.
  function automatic logic [8:0] expCtrl();
    bit mstall, lu, mh;
    if (!nrst) return V_NONE;
    mstall = (mem_req && !mem_ready) || (in_wait && !mem_ready);
    lu = ex_memread && (ex_rd != 5'd0) &&
         ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    mh = (md_rem > 0) && (id_md_read || id_md_start);
    if (mstall) return V_MEM;
    if (ex_branch_taken) return V_BRANCH;
    if (lu || mh) return V_INTLK;
    return V_NONE;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      md_rem = 0;
      in_wait = 1'b0;
      wait_cycles = 0;
      tmo = 1'b0;
      exp_stall_cnt = '0;
      exp_flush_cnt = '0;
    end else begin
      model_vec = expCtrl();
      model_mstall = (mem_req && !mem_ready) || (in_wait && !mem_ready);
      if (model_vec[8]) exp_stall_cnt = exp_stall_cnt + 1;
      if (ex_branch_taken && !model_mstall) exp_flush_cnt = exp_flush_cnt + 1;
      if (id_md_start && !model_vec[8] && !model_vec[4]) md_rem = MD_LAT;
      else if (md_rem > 0) md_rem = md_rem - 1;
      if (!in_wait) begin
        if (mem_req && !mem_ready) begin
          in_wait = 1'b1;
          wait_cycles = 1;
        end
      end else if (mem_ready) begin
        in_wait = 1'b0;
        wait_cycles = 0;
      end else if (wait_cycles < 255) begin
        wait_cycles = wait_cycles + 1;
      end
      if (in_wait && wait_cycles == MEM_TO) tmo = 1'b1;
    end
  end

  task automatic checkOutput();
    check1("ctrl_vector", 32'(dut_vec), 32'(expCtrl()));
    check1("md_busy", 32'(md_busy), 32'(md_rem > 0));
    check1("mem_timeout", 32'(mem_timeout), 32'(tmo));
    check1("state", 32'(state), 32'(in_wait));
`ifdef HAZ_PERF_CNT_EN
    check1("perf_stall_cycles", perf_stall_cycles, exp_stall_cnt);
    check1("perf_flushes", perf_flushes, exp_flush_cnt);
`else
    check1("perf_stall_cycles", perf_stall_cycles, 32'd0);
    check1("perf_flushes", perf_flushes, 32'd0);
`endif
  endtask

  always @(negedge clk) checkOutput();

  task automatic applyStimulus(input stim_t s);
    id_rs           = s.rs;
    id_rt           = s.rt;
    id_uses_rs      = s.uses_rs;
    id_uses_rt      = s.uses_rt;
    id_md_start     = s.md_start;
    id_md_read      = s.md_read;
    ex_memread      = s.ex_memread;
    ex_rd           = s.ex_rd;
    ex_branch_taken = s.branch;
    mem_req         = s.mem_req;
    mem_ready       = s.mem_ready;
  endtask

  task automatic driveCycle(input stim_t s);
    @(posedge clk);
    #1;
    applyStimulus(s);
    #2;
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    s.mem_ready = 1'b1;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.rs         = 5'($urandom_range(0, 3));
    s.rt         = 5'($urandom_range(0, 3));
    s.uses_rs    = ($urandom_range(0, 99) < 70);
    s.uses_rt    = ($urandom_range(0, 99) < 50);
    s.md_start   = ($urandom_range(0, 99) < 12);
    s.md_read    = ($urandom_range(0, 99) < 15);
    s.ex_memread = ($urandom_range(0, 99) < 40);
    s.ex_rd      = 5'($urandom_range(0, 3));
    s.branch     = ($urandom_range(0, 99) < 15);
    s.mem_req    = ($urandom_range(0, 99) < 30);
    s.mem_ready  = ($urandom_range(0, 99) < 70);
    return s;
  endfunction

  initial begin
    stim_t s;
    applyStimulus(idleStim());
    #3;
    check1("reset_ctrl", 32'(dut_vec), 32'(V_NONE));
    check1("reset_state", 32'(state), 32'd0);
    check1("reset_busy", 32'(md_busy), 32'd0);
    check1("reset_timeout", 32'(mem_timeout), 32'd0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;

    // Load-use: lw r5 in EX, add reading r5 in ID.
    s = idleStim();
    s.ex_memread = 1'b1; s.ex_rd = 5'd5; s.rs = 5'd5; s.uses_rs = 1'b1;
    driveCycle(s);
    check1("load_use_ctrl", 32'(dut_vec), 32'(V_INTLK));
    s.ex_rd = 5'd0; s.rs = 5'd0;
    driveCycle(s);
    check1("load_use_r0_ctrl", 32'(dut_vec), 32'(V_NONE));
    s.ex_rd = 5'd5; s.rs = 5'd5; s.branch = 1'b1;
    driveCycle(s);
    check1("branch_over_load_use", 32'(dut_vec), 32'(V_BRANCH));

    // Memory wait with a taken branch held throughout.
    s = idleStim();
    s.branch = 1'b1; s.mem_req = 1'b1; s.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      driveCycle(s);
      check1("mem_wait_ctrl", 32'(dut_vec), 32'(V_MEM));
      check1("mem_wait_state", 32'(state), (i == 0) ? 32'd0 : 32'd1);
    end
    s.mem_ready = 1'b1;
    driveCycle(s);
    check1("mem_ready_flush", 32'(dut_vec), 32'(V_BRANCH));
    driveCycle(idleStim());
    check1("mem_back_to_run", 32'(state), 32'd0);

    // Mult then mflo: stalled while the result is pending.
    s = idleStim();
    s.md_start = 1'b1;
    driveCycle(s);
    check1("mult_accept", 32'(pc_stall), 32'd0);
    driveCycle(idleStim());
    check1("mult_busy_t0", 32'(md_busy), 32'd1);
    driveCycle(idleStim());
    s = idleStim();
    s.md_read = 1'b1;
    for (int t = 2; t <= 7; t++) begin
      driveCycle(s);
      check1("mflo_interlock", 32'(dut_vec), 32'(V_INTLK));
    end
    check1("mult_busy_t7", 32'(md_busy), 32'd1);
    driveCycle(s);
    check1("mflo_advance", 32'(pc_stall), 32'd0);
    check1("mult_busy_t8", 32'(md_busy), 32'd0);
    driveCycle(idleStim());

    // Timeout after MEM_TO wait cycles, sticky past ready.
    s = idleStim();
    s.mem_req = 1'b1; s.mem_ready = 1'b0;
    driveCycle(s);
    check1("timeout_enter_state", 32'(state), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      driveCycle(s);
      check1("timeout_wait_state", 32'(state), 32'd1);
      check1("timeout_flag", 32'(mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
    end
    s.mem_ready = 1'b1;
    driveCycle(s);
    check1("timeout_ready_ctrl", 32'(dut_vec), 32'(V_NONE));
    check1("timeout_sticky", 32'(mem_timeout), 32'd1);
    driveCycle(idleStim());
    check1("timeout_sticky_run", 32'(mem_timeout), 32'd1);

    // Async reset in MEM_WAIT with the mult counter at 5.
    s = idleStim();
    s.md_start = 1'b1;
    driveCycle(s);
    s = idleStim();
    s.mem_req = 1'b1; s.mem_ready = 1'b0;
    repeat (4) driveCycle(s);
    check1("pre_reset_state", 32'(state), 32'd1);
    check1("pre_reset_busy", 32'(md_busy), 32'd1);
    nrst = 1'b0;
    #1;
    check1("async_reset_ctrl", 32'(dut_vec), 32'(V_NONE));
    check1("async_reset_state", 32'(state), 32'd0);
    check1("async_reset_busy", 32'(md_busy), 32'd0);
    check1("async_reset_timeout", 32'(mem_timeout), 32'd0);
    applyStimulus(idleStim());
    @(posedge clk);
    #1 nrst = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      driveCycle(randStim());
      if ($urandom_range(0, 599) == 0) begin
        nrst = 1'b0;
        #3 nrst = 1'b1;
      end
    end

    driveCycle(idleStim());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/bubble controller for the 5-stage MIPS pipeline. Drives the stall and bubble inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves:
- load-use hazards
- taken-branch flushes
- multiply/divide result interlocks
- data-memory wait states

Sits beside the datapath; consumes decoded ID/EX/MEM fields and emits per-stage control.

Parameters:
MD_LATENCY, 8, cycles the mult/div unit is busy after an accepted start (1..31).
MEM_TIMEOUT, 64, MEM_WAIT cycles before o_mem_timeout is raised (1..255).

Ports:
clk  in  1  clock
nrst  in  1  reset, asynchronous, active-low
i_id_rs  in  5  rs field of the instruction in ID
i_id_rt  in  5  rt field of the instruction in ID
i_id_uses_rs  in  1  ID instruction reads rs
i_id_uses_rt  in  1  ID instruction reads rt
i_id_md_start  in  1  ID instruction is mult/multu/div/divu
i_id_md_read  in  1  ID instruction is mfhi/mflo
i_ex_memread  in  1  EX instruction is a load
i_ex_rd  in  5  destination register of the EX instruction
i_ex_branch_taken  in  1  branch/jump resolved taken in EX
i_mem_req  in  1  MEM stage issuing a data-memory access
i_mem_ready  in  1  data memory completes the access this cycle
o_pc_stall  out  1  hold PC
o_ifid_stall, o_ifid_bubble  out  1 each  IF/ID controls
o_idex_stall, o_idex_bubble  out  1 each  ID/EX controls
o_exmem_stall, o_exmem_bubble  out  1 each  EX/MEM controls
o_memwb_stall, o_memwb_bubble  out  1 each  MEM/WB controls
o_md_busy  out  1  mult/div result pending
o_mem_timeout  out  1  sticky memory-timeout error
o_state  out  2  FSM state (0 RUN, 1 MEM_WAIT)
o_perf_stall_cycles  out  32  stall-cycle count (optional feature)
o_perf_flushes  out  32  flush count (optional feature)

Behaviour:
- Reset (nrst low, async): state=RUN, md_cnt=0, wait_cnt=0, o_mem_timeout=0, perf counters=0.
- Reset mid-operation: the FSM abandons MEM_WAIT immediately and md_cnt clears.
- All stall/bubble outputs are combinational from the current state and inputs. They are 0 while in reset.
- Hazard terms:
  - load_use = i_ex_memread & (i_ex_rd!=0) & ((i_id_uses_rs & i_id_rs==i_ex_rd) | (i_id_uses_rt & i_id_rt==i_ex_rd))
  - md_hold = o_md_busy & (i_id_md_read | i_id_md_start)
  - mem_hold = i_mem_req & ~i_mem_ready
- Priority, highest first:
  1. mem_hold, or state==MEM_WAIT with ~i_mem_ready: all five stalls=1, all bubbles=0.
  2. i_ex_branch_taken: o_ifid_bubble=1, o_idex_bubble=1; no stalls; PC loads the target.
  3. load_use | md_hold: o_pc_stall=1, o_ifid_stall=1, o_idex_bubble=1.
  4. Otherwise all outputs 0.
- A branch taken during a memory wait remains asserted because EX is frozen. The flush is applied in the cycle i_mem_ready rises.
- FSM:
  - RUN -> MEM_WAIT when mem_hold; wait_cnt=1.
  - MEM_WAIT -> RUN on i_mem_ready; wait_cnt=0.
  - While in MEM_WAIT, wait_cnt increments, saturating at 255. When wait_cnt==MEM_TIMEOUT, o_mem_timeout sets and holds until reset. Stalling continues regardless.
- md_cnt (5 bit):
  - Loads MD_LATENCY when i_id_md_start & ~o_pc_stall & ~o_idex_bubble, i.e. the instruction advances.
  - Otherwise decrements when nonzero, including during memory stalls.
  - o_md_busy = md_cnt!=0.
- A start issued in the cycle md_cnt reaches 1 is interlocked. It is accepted the next cycle.

Optional Feature:
HAZ_PERF_CNT_EN defined:
- o_perf_stall_cycles increments, wrapping, on every cycle with o_pc_stall=1.
- o_perf_flushes increments on every cycle with i_ex_branch_taken and no memory hold.

Undefined: both ports are tied to 0 and no counter flops exist. The ports are always present.

Decomposition:
Shared package pipe_ctrl_pkg holds:
- FSM state encoding ST_RUN / ST_MEM_WAIT
- REG_ZERO=5'd0
- default MD_LATENCY and MEM_TIMEOUT constants

The hazard compare logic is small and stays inline. One sub-module, md_busy_counter (load/decrement/busy), is natural and is reused by the divider.

Test Plan:
- Load-use: EX lw rd=5, ID add rs=5 uses_rs=1 -> one cycle of pc_stall=ifid_stall=idex_bubble=1; with i_ex_rd=0 -> no stall.
- Branch vs load-use: same cycle taken=1 and load_use=1 -> ifid_bubble=idex_bubble=1, pc_stall=0; flush counter +1 when HAZ_PERF_CNT_EN is defined.
- Mem wait: i_mem_req=1, ready low for 3 cycles -> all stalls=1 for 3 cycles, o_state=1, then RUN on ready; branch held taken throughout -> flush occurs in the ready cycle only.
- Mult interlock: mult accepted at t0 with MD_LATENCY=8, mflo in ID at t2 -> stalled through t7, advances at t8; o_md_busy falls after t7.
- Timeout: MEM_TIMEOUT=4, ready held low -> o_mem_timeout=1 on the 4th MEM_WAIT cycle and stays 1 after ready; nrst pulse clears it and returns o_state=0.
- Async reset during MEM_WAIT with md_cnt=5 -> all outputs 0 immediately, without a clock edge.
